adder_stream_driver: RTL and testbench
======================================

ADDER_STREAM_DRIVER -- requirements
Module: adder_stream_driver

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width in bits.
REQ-002 SHALL have parameter NUM_TXN, default 16, transactions per run (1..255).
REQ-003 SHALL have parameter MAX_OUT, default 4, maximum operands issued ahead of the sums received, per stream (1..15).
REQ-004 SHALL have the following ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a run.
- a_vld  out  1  operand A valid.
- a_rdy  in  1  operand A ready.
- a_data  out  WIDTH  operand A.
- b_vld  out  1  operand B valid.
- b_rdy  in  1  operand B ready.
- b_data  out  WIDTH  operand B.
- sum_vld  in  1  sum valid.
- sum_rdy  out  1  sum ready.
- sum_data  in  WIDTH+1  sum, carry in the MSB.
- busy  out  1  run in progress.
- done  out  1  run complete.
- pass  out  1  run completed with zero mismatches.
- err_cnt  out  8  mismatch count.

Function
REQ-005 SHALL implement FSM IDLE -> RUN on start; RUN -> DONE in the cycle after the NUM_TXN-th sum handshake; DONE -> RUN on start.
- On entry to RUN: clear counters a_idx, b_idx, r_idx and err_cnt.
- start is ignored in RUN.
REQ-006 SHALL count a handshake on a stream when vld and rdy are both 1 at a rising clk edge.
REQ-007 SHALL drive a_data = a_idx mod 2^WIDTH and b_data = (3*b_idx+1) mod 2^WIDTH.
REQ-008 SHALL increment a_idx on each A handshake and b_idx on each B handshake; the two streams advance independently.
REQ-009 SHALL assert a_vld only in RUN with a_idx < NUM_TXN and (a_idx - r_idx) < MAX_OUT; b_vld uses the same rule with b_idx.
REQ-010 SHALL hold a_vld and a_data (and likewise b_vld and b_data) stable from assertion until the handshake.
REQ-011 SHALL compute the expected sum for receive index r as (r mod 2^WIDTH) + ((3r+1) mod 2^WIDTH), zero-extended to WIDTH+1 bits.
REQ-012 SHALL drive sum_rdy = 1 in RUN while r_idx < NUM_TXN, and 0 otherwise (see REQ-019).
REQ-013 SHALL, on each sum handshake, compare sum_data with the expected sum for r_idx, increment r_idx, and increment err_cnt on mismatch, saturating at 255.
REQ-014 SHALL ignore sum_vld in IDLE and DONE; no count change.
REQ-015 SHALL drive busy = (state == RUN), done = (state == DONE), and pass = done && (err_cnt == 0).
REQ-016 SHALL treat an A handshake, a B handshake and a sum handshake in the same cycle as independent updates; the outstanding check uses the pre-edge r_idx.

Reset
REQ-017 SHALL, while rst_n = 0, asynchronously force state to IDLE, all counters to 0, and a_vld, b_vld, sum_rdy, busy, done, pass and err_cnt to 0.
REQ-018 SHALL, when reset is asserted mid-run, abandon the run; the next start begins a full run from index 0.

Configuration
REQ-019 SHALL support macro ADDER_STREAM_DRIVER_BACKPRESSURE_EN:
- Defined: sum_rdy in RUN is additionally gated by bit 0 of an 8-bit LFSR (x^8+x^6+x^5+x^4+1, reset seed 8'hA5, advancing every cycle), producing pseudo-random stalls.
- Undefined: no LFSR is present and sum_rdy follows REQ-012 exactly.

Verification
REQ-020 SHALL cover: reset with rst_n = 0 -> a_vld, b_vld, sum_rdy, busy, done, pass all 0 and err_cnt = 0.
REQ-021 SHALL cover: correct always-ready combinational adder, start pulse -> 16 sum handshakes; the k = 15 pair is a = 15, b = 14, sum = 29; then done = 1, pass = 1, err_cnt = 0.
REQ-022 SHALL cover: responder returns expected+1 at k = 3 only -> err_cnt = 1, pass = 0 at done.
REQ-023 SHALL cover: a_rdy held 0, b_rdy = 1 -> a_vld = 1 with a_data = 0 held stable; b_vld drops after 4 B handshakes and stays 0 until sums arrive.
REQ-024 SHALL cover: rst_n pulsed low after 7 sums -> IDLE with counters 0; a new start completes 16 transactions with pass = 1.
REQ-025 SHALL cover: with ADDER_STREAM_DRIVER_BACKPRESSURE_EN defined -> sum_rdy shows stall cycles, sum_vld and sum_data are held by the responder through stalls, and the run still ends with pass = 1.

Source files
------------

// File: rtl/adder_stream_driver_if.sv
// Operand/sum stream bundle between adder_stream_driver (master) and the adder under test (slave).
interface adder_stream_driver_if #(
  parameter int unsigned WIDTH = 4
);
  logic             a_vld;
  logic             a_rdy;
  logic [WIDTH-1:0] a_data;
  logic             b_vld;
  logic             b_rdy;
  logic [WIDTH-1:0] b_data;
  logic             sum_vld;
  logic             sum_rdy;
  logic [WIDTH:0]   sum_data;

  modport master (
    output a_vld, a_data, b_vld, b_data, sum_rdy,
    input  a_rdy, b_rdy, sum_vld, sum_data
  );

  modport slave (
    input  a_vld, a_data, b_vld, b_data, sum_rdy,
    output a_rdy, b_rdy, sum_vld, sum_data
  );
endinterface

// File: rtl/adder_stream_driver.sv
// Drives two operand streams into an adder, checks the returned sums and reports pass/fail.
// Optional pseudo-random sum backpressure: define ADDER_STREAM_DRIVER_BACKPRESSURE_EN.
module adder_stream_driver #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned NUM_TXN = 16,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  adder_stream_driver_if.master        bus,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [7:0]                   err_cnt
);

  localparam int unsigned IDX_W = 8;
  localparam int unsigned OUT_W = IDX_W + 1;
  localparam int unsigned MUL_W = 10;
  localparam int unsigned SUM_W = WIDTH + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   a_idx_q, a_idx_d;
  logic [IDX_W-1:0]   b_idx_q, b_idx_d;
  logic [IDX_W-1:0]   r_idx_q, r_idx_d;
  logic [7:0]         err_q, err_d;
  logic               a_vld_q, a_vld_d;
  logic               b_vld_q, b_vld_d;
  logic               sum_rdy_q, sum_rdy_d;
  logic [WIDTH-1:0]   a_data_q, a_data_d;
  logic [WIDTH-1:0]   b_data_q, b_data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic               a_hs, b_hs, sum_hs;
`ifdef ADDER_STREAM_DRIVER_BACKPRESSURE_EN
  logic [7:0]         lfsr_q, lfsr_d;
`endif

  function automatic logic [WIDTH-1:0] a_val(input logic [IDX_W-1:0] idx);
    return WIDTH'(idx);
  endfunction

  function automatic logic [WIDTH-1:0] b_val(input logic [IDX_W-1:0] idx);
    logic [MUL_W-1:0] t;
    t = MUL_W'(idx) * MUL_W'(3) + MUL_W'(1);
    return WIDTH'(t);
  endfunction

  function automatic logic [SUM_W-1:0] exp_sum(input logic [IDX_W-1:0] idx);
    return SUM_W'(a_val(idx)) + SUM_W'(b_val(idx));
  endfunction

  // Issue only while operands remain and the stream is not too far ahead of the sums.
  function automatic logic may_issue(input logic [IDX_W-1:0] idx, input logic [IDX_W-1:0] r);
    return (idx < IDX_W'(NUM_TXN)) && (OUT_W'(idx) < OUT_W'(r) + OUT_W'(MAX_OUT));
  endfunction

  assign a_hs   = a_vld_q & bus.a_rdy;
  assign b_hs   = b_vld_q & bus.b_rdy;
  assign sum_hs = sum_rdy_q & bus.sum_vld;

  always_comb begin
    state_d = state_q;
    a_idx_d = a_idx_q;
    b_idx_d = b_idx_q;
    r_idx_d = r_idx_q;
    err_d   = err_q;
`ifdef ADDER_STREAM_DRIVER_BACKPRESSURE_EN
    lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`endif

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          a_idx_d = '0;
          b_idx_d = '0;
          r_idx_d = '0;
          err_d   = '0;
        end
      end
      RUN: begin
        if (a_hs) a_idx_d = a_idx_q + IDX_W'(1);
        if (b_hs) b_idx_d = b_idx_q + IDX_W'(1);
        if (sum_hs) begin
          r_idx_d = r_idx_q + IDX_W'(1);
          if ((bus.sum_data != exp_sum(r_idx_q)) && (err_q != 8'hFF)) err_d = err_q + 8'd1;
        end
        if (r_idx_q == IDX_W'(NUM_TXN)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    // Registered outputs are derived from the post-edge counters.
    a_vld_d   = (state_d == RUN) && may_issue(a_idx_d, r_idx_d);
    b_vld_d   = (state_d == RUN) && may_issue(b_idx_d, r_idx_d);
    a_data_d  = a_val(a_idx_d);
    b_data_d  = b_val(b_idx_d);
    sum_rdy_d = (state_d == RUN) && (r_idx_d < IDX_W'(NUM_TXN));
`ifdef ADDER_STREAM_DRIVER_BACKPRESSURE_EN
    sum_rdy_d = sum_rdy_d && lfsr_d[0];
`endif
    busy_d    = (state_d == RUN);
    done_d    = (state_d == DONE);
    pass_d    = done_d && (err_d == 8'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_idx_q   <= '0;
      b_idx_q   <= '0;
      r_idx_q   <= '0;
      err_q     <= '0;
      a_vld_q   <= 1'b0;
      b_vld_q   <= 1'b0;
      sum_rdy_q <= 1'b0;
      a_data_q  <= '0;
      b_data_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_idx_q   <= a_idx_d;
      b_idx_q   <= b_idx_d;
      r_idx_q   <= r_idx_d;
      err_q     <= err_d;
      a_vld_q   <= a_vld_d;
      b_vld_q   <= b_vld_d;
      sum_rdy_q <= sum_rdy_d;
      a_data_q  <= a_data_d;
      b_data_q  <= b_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

`ifdef ADDER_STREAM_DRIVER_BACKPRESSURE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 8'hA5;
    else        lfsr_q <= lfsr_d;
  end
`endif

  assign bus.a_vld   = a_vld_q;
  assign bus.a_data  = a_data_q;
  assign bus.b_vld   = b_vld_q;
  assign bus.b_data  = b_data_q;
  assign bus.sum_rdy = sum_rdy_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign err_cnt     = err_q;

endmodule

// File: tb/tb_adder_stream_driver.sv
// Randomized bench: acts as the adder (operand sinks + sum source) and checks against a transaction-level model.
module tb_adder_stream_driver;

  localparam int W = 4;
  localparam int N = 16;
  localparam int M = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       busy, done, pass;
  logic [7:0] err_cnt;

  int vec_cnt = 0;
  int miscmp  = 0;

  int a_k, b_k, r_done, stall_cnt, stall_total;
  bit in_run, mdone, fin_pend, sum_pend;
  int qa[$];
  int qb[$];

  always #5 clk = ~clk;

  adder_stream_driver_if #(.WIDTH(W)) bus();

  adder_stream_driver #(.WIDTH(W), .NUM_TXN(N), .MAX_OUT(M)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bus     (bus),
    .busy    (busy),
    .done    (done),
    .pass    (pass),
    .err_cnt (err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_a_vld"},   32'(bus.a_vld),   32'd0);
    check({tag, "_b_vld"},   32'(bus.b_vld),   32'd0);
    check({tag, "_sum_rdy"}, 32'(bus.sum_rdy), 32'd0);
    check({tag, "_busy"},    32'(busy),        32'd0);
    check({tag, "_done"},    32'(done),        32'd0);
    check({tag, "_pass"},    32'(pass),        32'd0);
    check({tag, "_err_cnt"}, 32'(err_cnt),     32'd0);
  endtask

  task automatic apply_reset();
    rst_n       = 1'b0;
    start       = 1'b0;
    bus.a_rdy   = 1'b0;
    bus.b_rdy   = 1'b0;
    bus.sum_vld = 1'b0;
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One run: inject>=0 corrupts that sum by +1; stop_sums>0 leaves early; a_stall holds a_rdy low.
  task automatic run(input int inject, input int stop_sums, input bit a_stall);
    int  ta, tb, s;
    bit  left;
    a_k = 0; b_k = 0; r_done = 0; stall_cnt = 0;
    qa.delete(); qb.delete();
    in_run = 1'b1; mdone = 1'b0; fin_pend = 1'b0; sum_pend = 1'b0; left = 1'b0;
    bus.sum_vld = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (sum_pend) begin
        r_done++;
        bus.sum_vld = 1'b0;
        sum_pend    = 1'b0;
      end
      if (fin_pend) begin
        in_run = 1'b0; mdone = 1'b1; fin_pend = 1'b0;
      end
      if (in_run && r_done == N) fin_pend = 1'b1;

      check("busy",  32'(busy), 32'(in_run));
      check("done",  32'(done), 32'(mdone));
      check("a_vld", 32'(bus.a_vld), 32'(in_run && a_k < N && (a_k - r_done) < M));
      check("b_vld", 32'(bus.b_vld), 32'(in_run && b_k < N && (b_k - r_done) < M));
`ifdef ADDER_STREAM_DRIVER_BACKPRESSURE_EN
      check("sum_rdy_gate", 32'(bus.sum_rdy && !(in_run && r_done < N)), 32'd0);
`else
      check("sum_rdy", 32'(bus.sum_rdy), 32'(in_run && r_done < N));
`endif
      if (mdone) begin left = 1'b1; break; end
      if (stop_sums > 0 && r_done == stop_sums) begin left = 1'b1; break; end
      if (a_stall && cyc == 20) begin left = 1'b1; break; end

      start = (cyc == 5);
      if (bus.a_vld) check("a_data", 32'(bus.a_data), 32'(a_k % (1 << W)));
      if (bus.b_vld) check("b_data", 32'(bus.b_data), 32'((3 * b_k + 1) % (1 << W)));

      bus.a_rdy = a_stall ? 1'b0 : ($urandom_range(3) != 0);
      bus.b_rdy = a_stall ? 1'b1 : ($urandom_range(3) != 0);
      if (bus.a_vld && bus.a_rdy) begin qa.push_back(int'(bus.a_data)); a_k++; end
      if (bus.b_vld && bus.b_rdy) begin qb.push_back(int'(bus.b_data)); b_k++; end

      if (!bus.sum_vld && qa.size() > 0 && qb.size() > 0 && $urandom_range(9) < 7) begin
        ta = qa.pop_front();
        tb = qb.pop_front();
        s  = ta + tb;
        if (r_done == 15) check("k15_sum", 32'(s), 32'd29);
        if (r_done == inject) s++;
        bus.sum_data = (W + 1)'(s);
        bus.sum_vld  = 1'b1;
      end
      if (bus.sum_vld && bus.sum_rdy) sum_pend = 1'b1;
      else if (bus.sum_vld)           stall_cnt++;
      @(negedge clk);
    end
    start = 1'b0;
    if (!left) check("run_timeout", 32'd1, 32'd0);
    stall_total += stall_cnt;
  endtask

  initial begin
    stall_total = 0;
    bus.sum_data = '0;
    apply_reset();

    // Clean run with a correct adder.
    run(-1, 0, 1'b0);
    check("clean_err_cnt", 32'(err_cnt), 32'd0);
    check("clean_pass",    32'(pass),    32'd1);

    // One corrupted sum at k = 3.
    run(3, 0, 1'b0);
    check("inj_err_cnt", 32'(err_cnt), 32'd1);
    check("inj_pass",    32'(pass),    32'd0);
    check("inj_done",    32'(done),    32'd1);

    // A stream stalled: B runs MAX_OUT ahead then stops.
    run(-1, 0, 1'b1);
    check("stall_a_hs", 32'(a_k), 32'd0);
    check("stall_b_hs", 32'(b_k), 32'(M));
    check("stall_a_data", 32'(bus.a_data), 32'd0);
    apply_reset();

    // Reset mid-run after 7 sums, then a full run.
    run(-1, 7, 1'b0);
    check("mid_sums", 32'(r_done), 32'd7);
    apply_reset();
    run(-1, 0, 1'b0);
    check("rerun_err_cnt", 32'(err_cnt), 32'd0);
    check("rerun_pass",    32'(pass),    32'd1);

`ifdef ADDER_STREAM_DRIVER_BACKPRESSURE_EN
    check("bp_stalls_seen", 32'(stall_total > 0), 32'd1);
`else
    check("no_stalls", 32'(stall_total), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

endmodule
